// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, runs the IDLE/REQ/ACCESS
// bus-master handshake and drives the IF/ID register (if_pc, if_insn, if_en_).
// Optional feature macro: IF_PREFETCH_BUF_EN adds a one-entry buffer that keeps
// a word returned during stall instead of discarding and refetching it.
module if_stage #(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter logic [31:0] NOP_INSN     = 32'h0
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        new_pc_valid,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    output logic        busy,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en_
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_e;

    state_e      state_q;
    logic [29:0] pc_q, pc_d;
    logic [29:0] bus_addr_q;
    logic        bus_req_q, bus_as_q, busy_q;
    logic        discard_q;     // in-flight word was overtaken by a redirect/flush
    logic [29:0] if_pc_q;
    logic [31:0] if_insn_q;
    logic        if_en_q;       // active-low valid of the IF/ID register

    logic        redirect;
    logic [29:0] target;
    logic        word_ok;       // word completing this cycle is still wanted
    logic        keep_word;     // word completing this cycle advances the pc
    logic        idle_go;       // IDLE may start a new request

`ifdef IF_PREFETCH_BUF_EN
    logic        buf_valid_q;
    logic [29:0] buf_pc_q;
    logic [31:0] buf_insn_q;
    logic        buf_drain;
`endif

    // Redirect arbitration, fate of a completing word and next pc
    always_comb begin
        redirect  = new_pc_valid | br_taken;
        target    = new_pc_valid ? new_pc : br_addr;
        word_ok   = (state_q == ACCESS) && !bus_rdy_ && !redirect && !flush && !discard_q;
`ifdef IF_PREFETCH_BUF_EN
        keep_word = word_ok;
        buf_drain = buf_valid_q && !stall && !redirect && !flush;
        idle_go   = !stall && !buf_valid_q;
`else
        keep_word = word_ok && !stall;
        idle_go   = !stall;
`endif
        // NOTE: pc_d gets a default before any conditional update so no latch is inferred.
        pc_d = pc_q;
        if (redirect) begin
            pc_d = target;
        end else if (keep_word) begin
            pc_d = pc_q + 30'd1;
        end
    end

    // PC, IF/ID register, prefetch buffer and bus FSM with registered outputs
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            pc_q        <= RESET_VECTOR;
            bus_addr_q  <= 30'h0;
            bus_req_q   <= 1'b1;
            bus_as_q    <= 1'b1;
            busy_q      <= 1'b0;
            discard_q   <= 1'b0;
            if_pc_q     <= RESET_VECTOR;
            if_insn_q   <= NOP_INSN;
            if_en_q     <= 1'b1;
`ifdef IF_PREFETCH_BUF_EN
            // NOTE: the buffer payload is a single register, so it is cleared with the rest.
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 30'h0;
            buf_insn_q  <= 32'h0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pc_q <= pc_d;

            // IF/ID register: invalidate on redirect/flush, load a fresh word, else hold
            if (redirect || flush) begin
                if_insn_q <= NOP_INSN;
                if_en_q   <= 1'b1;
            end else if (word_ok && !stall) begin
                if_insn_q <= bus_rd_data;
                if_pc_q   <= pc_q;
                if_en_q   <= 1'b0;
            end
`ifdef IF_PREFETCH_BUF_EN
            else if (buf_drain) begin
                if_insn_q <= buf_insn_q;
                if_pc_q   <= buf_pc_q;
                if_en_q   <= 1'b0;
            end

            if (redirect || flush) begin
                buf_valid_q <= 1'b0;
            end else if (word_ok && stall) begin
                buf_valid_q <= 1'b1;
                buf_pc_q    <= pc_q;
                buf_insn_q  <= bus_rd_data;
            end else if (buf_drain) begin
                buf_valid_q <= 1'b0;
            end
`endif

            case (state_q)
                IDLE: begin
                    if (idle_go) begin
                        state_q   <= REQ;
                        bus_req_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                REQ: begin
                    if (!bus_grnt_) begin
                        state_q    <= ACCESS;
                        bus_addr_q <= pc_d;
                        bus_as_q   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (redirect || flush) begin
                        discard_q <= 1'b1;
                    end
                    if (!bus_rdy_) begin
                        bus_as_q  <= 1'b1;
                        discard_q <= 1'b0;
                        if (stall) begin
                            state_q   <= IDLE;
                            bus_req_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign bus_req_ = bus_req_q;
    assign bus_addr = bus_addr_q;
    assign bus_as_  = bus_as_q;
    assign bus_rw   = 1'b1;
    assign if_pc    = if_pc_q;
    assign if_insn  = if_insn_q;
    assign if_en_   = if_en_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage with a bus-slave responder and a
// transaction-level model of pc / IF/ID contents checked every cycle.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0;

    logic        clk, reset_, stall, flush, new_pc_valid, br_taken;
    logic [29:0] new_pc, br_addr;
    logic        busy, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_, if_en_;
    logic [29:0] bus_addr, if_pc;
    logic [31:0] bus_rd_data, if_insn;

    int checks = 0;
    int errors = 0;
    int gnt_dly = 0;
    int rdy_dly = 0;
    int req_cnt, acc_cnt;

    if_stage dut (
        .clk          (clk),
        .reset_       (reset_),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .new_pc_valid (new_pc_valid),
        .br_taken     (br_taken),
        .br_addr      (br_addr),
        .busy         (busy),
        .bus_req_     (bus_req_),
        .bus_grnt_    (bus_grnt_),
        .bus_addr     (bus_addr),
        .bus_as_      (bus_as_),
        .bus_rw       (bus_rw),
        .bus_rd_data  (bus_rd_data),
        .bus_rdy_     (bus_rdy_),
        .if_pc        (if_pc),
        .if_insn      (if_insn),
        .if_en_       (if_en_)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents seen by the fetch unit
    function automatic logic [31:0] data_of(input logic [29:0] a);
        if (a == 30'h0) return 32'h1234_5678;
        return {2'b01, a} ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus slave: grant after gnt_dly request cycles, ready after rdy_dly strobe cycles
    initial begin
        bus_grnt_   = 1'b1;
        bus_rdy_    = 1'b1;
        bus_rd_data = 32'hDEAD_BEEF;
        req_cnt     = 0;
        acc_cnt     = 0;
        forever begin
            @(negedge clk);
            if (!reset_ || (bus_req_ && bus_as_)) begin
                bus_grnt_ = 1'b1;
                bus_rdy_  = 1'b1;
                req_cnt   = 0;
                acc_cnt   = 0;
            end else if (!bus_as_) begin
                req_cnt   = 0;
                bus_grnt_ = 1'b1;
                if (acc_cnt >= rdy_dly) begin
                    bus_rdy_    = 1'b0;
                    bus_rd_data = data_of(bus_addr);
                end else begin
                    bus_rdy_    = 1'b1;
                    bus_rd_data = 32'hDEAD_BEEF;
                end
                acc_cnt++;
            end else begin
                acc_cnt   = 0;
                bus_rdy_  = 1'b1;
                bus_grnt_ = (req_cnt >= gnt_dly) ? 1'b0 : 1'b1;
                req_cnt++;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    logic [29:0] m_pc, m_if_pc, m_acc_addr;
    logic [31:0] m_if_insn;
    logic        m_valid, m_tainted, prev_as;
`ifdef IF_PREFETCH_BUF_EN
    logic        m_buf_valid;
    logic [29:0] m_buf_pc;
    logic [31:0] m_buf_insn;
`endif
    logic        p_rst, p_stall, p_flush, p_nv, p_bt, p_as, p_rdy;
    logic [29:0] p_new_pc, p_br_addr;
    logic [31:0] p_data;

    task automatic model_reset();
        m_pc       = 30'h0;
        m_if_pc    = 30'h0;
        m_if_insn  = NOP;
        m_valid    = 1'b0;
        m_tainted  = 1'b0;
        m_acc_addr = 30'h0;
        prev_as    = 1'b1;
`ifdef IF_PREFETCH_BUF_EN
        m_buf_valid = 1'b0;
        m_buf_pc    = 30'h0;
        m_buf_insn  = 32'h0;
`endif
    endtask

    task automatic model_step();
        logic        redir, complete, word_ok;
        logic [29:0] tgt;
        redir    = p_nv || p_bt;
        tgt      = p_nv ? p_new_pc : p_br_addr;
        complete = !p_as && !p_rdy;
        word_ok  = complete && !redir && !p_flush && !m_tainted;
        if (!p_as && !complete && (redir || p_flush)) m_tainted = 1'b1;
        if (complete) m_tainted = 1'b0;
        if (word_ok && !p_stall) begin
            m_if_pc   = m_pc;
            m_if_insn = p_data;
            m_valid   = 1'b1;
            m_pc      = m_pc + 30'd1;
        end
`ifdef IF_PREFETCH_BUF_EN
        else if (word_ok && p_stall) begin
            m_buf_valid = 1'b1;
            m_buf_pc    = m_pc;
            m_buf_insn  = p_data;
            m_pc        = m_pc + 30'd1;
        end else if (m_buf_valid && !p_stall) begin
            m_if_pc     = m_buf_pc;
            m_if_insn   = m_buf_insn;
            m_valid     = 1'b1;
            m_buf_valid = 1'b0;
        end
        if (redir || p_flush) m_buf_valid = 1'b0;
`endif
        if (redir || p_flush) begin
            m_valid   = 1'b0;
            m_if_insn = NOP;
        end
        if (redir) m_pc = tgt;
    endtask

    task automatic model_compare();
        check("m_if_en_", if_en_, !m_valid);
        if (m_valid) begin
            check("m_if_pc", if_pc, m_if_pc);
            check("m_if_insn", if_insn, m_if_insn);
        end else begin
            check("m_if_insn_nop", if_insn, NOP);
        end
        check("m_bus_rw", bus_rw, 1'b1);
        check("m_busy_vs_req", busy, !bus_req_);
        if (!bus_as_) begin
            check("m_as_needs_req", bus_req_, 1'b0);
            if (prev_as) begin
                check("m_fetch_addr", bus_addr, m_pc);
                m_acc_addr = m_pc;
            end else begin
                check("m_addr_stable", bus_addr, m_acc_addr);
            end
        end
        prev_as = bus_as_;
    endtask

    // Sample inputs ahead of each edge, advance the model, compare just after it
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #4;
            p_rst     = reset_;
            p_stall   = stall;
            p_flush   = flush;
            p_nv      = new_pc_valid;
            p_new_pc  = new_pc;
            p_bt      = br_taken;
            p_br_addr = br_addr;
            p_as      = bus_as_;
            p_rdy     = bus_rdy_;
            p_data    = bus_rd_data;
            @(posedge clk);
            #1;
            if (!reset_ || !p_rst) model_reset();
            else model_step();
            model_compare();
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        logic prev_s, seen;
        prev_s = bus_as_;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (prev_s && !bus_as_) seen = 1'b1;
            prev_s = bus_as_;
        end
        check({name, "_strobe_seen"}, seen, 1'b1);
    endtask

    task automatic wait_valid(input string name, input logic [29:0] pc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (!if_en_ && if_pc == pc) seen = 1'b1;
        end
        check({name, "_valid_seen"}, seen, 1'b1);
    endtask

    task automatic wait_fetch_of(input string name, input logic [29:0] addr);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            if (!bus_as_ && bus_addr == addr) seen = 1'b1;
        end
        check({name, "_fetch_seen"}, seen, 1'b1);
    endtask

    initial begin
        reset_ = 1'b1; stall = 1'b0; flush = 1'b0;
        new_pc_valid = 1'b0; new_pc = 30'h0; br_taken = 1'b0; br_addr = 30'h0;
        #2 reset_ = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_bus_req_", bus_req_, 1'b1);
        check("rst_bus_as_", bus_as_, 1'b1);
        check("rst_bus_addr", bus_addr, 30'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_if_pc", if_pc, 30'h0);
        check("rst_if_insn", if_insn, NOP);
        check("rst_if_en_", if_en_, 1'b1);

        // First fetch with immediate grant/ready: valid three edges after release
        reset_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("lat_not_yet_valid", if_en_, 1'b1);
            tick();
        end
        check("first_if_en_", if_en_, 1'b0);
        check("first_if_pc", if_pc, 30'h0);
        check("first_if_insn", if_insn, 32'h1234_5678);
        wait_start("second");
        check("second_addr", bus_addr, 30'h1);

        // Branch while the access at pc 5 is in flight, ready two cycles later
        rdy_dly = 2;
        wait_fetch_of("pc5", 30'h5);
        br_taken = 1'b1; br_addr = 30'h100;
        tick();
        br_taken = 1'b0;
        check("br_if_en_", if_en_, 1'b1);
        check("br_if_insn", if_insn, NOP);
        check("br_access_continues", bus_as_, 1'b0);
        wait_start("br_target");
        check("br_target_addr", bus_addr, 30'h100);
        check("br_word_discarded", if_en_, 1'b1);
        wait_valid("br_target", 30'h100);
        check("br_target_insn", if_insn, 32'h1A5A_5B5A);

        // new_pc_valid and br_taken together: new_pc wins
        wait_start("pri_pre");
        new_pc_valid = 1'b1; new_pc = 30'h40; br_taken = 1'b1; br_addr = 30'h80;
        tick();
        new_pc_valid = 1'b0; br_taken = 1'b0;
        wait_start("pri");
        check("pri_addr", bus_addr, 30'h40);
        wait_valid("pri", 30'h40);
        check("pri_insn", if_insn, 32'h1A5A_5A1A);

        // Stall for three cycles while the word at 0x41 completes
        wait_start("stall_pre");
        check("stall_access_addr", bus_addr, 30'h41);
        stall = 1'b1;
        tick(); tick(); tick();
        check("stall_if_pc", if_pc, 30'h40);
        check("stall_if_insn", if_insn, 32'h1A5A_5A1A);
        check("stall_if_en_", if_en_, 1'b0);
        check("stall_busy", busy, 1'b0);
        stall = 1'b0;
        tick();
`ifdef IF_PREFETCH_BUF_EN
        check("buf_if_pc", if_pc, 30'h41);
        check("buf_if_insn", if_insn, 32'h1A5A_5A1B);
        check("buf_if_en_", if_en_, 1'b0);
        check("buf_busy", busy, 1'b0);
        wait_start("after_buf");
        check("after_buf_addr", bus_addr, 30'h42);
`else
        check("unstall_if_pc", if_pc, 30'h40);
        check("unstall_if_en_", if_en_, 1'b0);
        wait_start("refetch");
        check("refetch_addr", bus_addr, 30'h41);
`endif

        // PC wrap at the top of the address space
        br_taken = 1'b1; br_addr = 30'h3FFF_FFFF;
        tick();
        br_taken = 1'b0;
        wait_valid("wrap", 30'h3FFF_FFFF);
        check("wrap_insn", if_insn, 32'h25A5_A5A5);
        wait_start("wrap_next");
        check("wrap_next_addr", bus_addr, 30'h0);

        // Flush during an access: IF/ID invalid, same address refetched
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_if_en_", if_en_, 1'b1);
        check("flush_if_insn", if_insn, NOP);
        wait_start("flush_refetch");
        check("flush_refetch_addr", bus_addr, 30'h0);
        wait_valid("flush_refetch", 30'h0);
        check("flush_refetch_insn", if_insn, 32'h1234_5678);

        // Asynchronous reset in the middle of an access
        wait_start("arst_pre");
        check("arst_pre_addr", bus_addr, 30'h1);
        #2 reset_ = 1'b0;
        #1;
        check("arst_bus_as_", bus_as_, 1'b1);
        check("arst_bus_req_", bus_req_, 1'b1);
        check("arst_if_en_", if_en_, 1'b1);
        check("arst_busy", busy, 1'b0);
        tick();
        reset_ = 1'b1;
        wait_start("arst_first");
        check("arst_first_addr", bus_addr, 30'h0);

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit %0d ns reached before the end", 100000);
        $fatal(1, "watchdog expired");
    end

endmodule
